// File: rtl/up_counter.sv
// up_counter: free-running binary up-counter with count enable and asynchronous clear.
//
// Parameters:
//   WIDTH        counter width in bits (>= 1)
//   RESET_VALUE  value loaded while reset is asserted
//
// Ports:
//   clock        in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high clear to RESET_VALUE
//   enable       in   1      count enable, sampled on the rising edge of clock
//   counter_out  out  WIDTH  registered count, wraps 2^WIDTH-1 -> 0
//   tc           out  1      terminal count, only when UP_COUNTER_TC_EN is defined
//
// Build option:
//   UP_COUNTER_TC_EN  adds the combinational terminal-count output tc
module up_counter #(
    parameter int unsigned           WIDTH       = 4,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] counter_out
`ifdef UP_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            counter_out <= RESET_VALUE;
        else if (enable)
            counter_out <= counter_out + 1'b1;
    end

`ifdef UP_COUNTER_TC_EN
    // Gated by reset so tc stays low even when RESET_VALUE is all ones.
    always_comb tc = enable & ~reset & (&counter_out);
`endif

endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: directed self-checking bench for up_counter (WIDTH=4 and WIDTH=8 instances).
module tb_up_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] counter_out;
    logic       reset8;
    logic       enable8;
    logic [7:0] counter_out8;
`ifdef UP_COUNTER_TC_EN
    logic       tc;
    logic       tc8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    up_counter #(.WIDTH(4), .RESET_VALUE(4'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .counter_out (counter_out)
`ifdef UP_COUNTER_TC_EN
        ,
        .tc          (tc)
`endif
    );

    up_counter #(.WIDTH(8), .RESET_VALUE(8'hF0)) dut8 (
        .clock       (clock),
        .reset       (reset8),
        .enable      (enable8),
        .counter_out (counter_out8)
`ifdef UP_COUNTER_TC_EN
        ,
        .tc          (tc8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        reset8  = 1'b1;
        enable8 = 1'b0;
        #1;
        check("t1_reset", 32'(counter_out), 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_idle", 32'(counter_out), 32'h0);
        end

        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("t2_count", 32'(counter_out), 32'(i));
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t2_hold", 32'(counter_out), 32'h5);
        end

        reset = 1'b1;
        #1;
        check("t3_async_clear", 32'(counter_out), 32'h0);
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
`ifdef UP_COUNTER_TC_EN
            check("t3_tc", 32'(tc), (i == 15) ? 32'h1 : 32'h0);
`endif
            step();
            check("t3_wrap", 32'(counter_out), 32'((i + 1) % 16));
        end

        for (int i = 1; i <= 5; i++) step();
        check("t4_pre", 32'(counter_out), 32'h5);
        enable = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("t4_mid_clear", 32'(counter_out), 32'h0);
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t4_held", 32'(counter_out), 32'h0);
        end
        reset = 1'b0;
        step();
        check("t4_resume", 32'(counter_out), 32'h1);

        reset = 1'b1;
        #1;
        reset = 1'b0;
        check("t5_start", 32'(counter_out), 32'h0);
        for (int i = 0; i < 8; i++) begin
            enable = (i % 2 == 0);
            step();
            check("t5_alt", 32'(counter_out), 32'((i + 2) / 2));
        end
        enable = 1'b0;

        check("t6_reset", 32'(counter_out8), 32'hF0);
        reset8  = 1'b0;
        enable8 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
`ifdef UP_COUNTER_TC_EN
            check("t6_tc", 32'(tc8), (i == 16) ? 32'h1 : 32'h0);
`endif
            step();
            check("t6_count", 32'(counter_out8), 32'((8'hF0 + i) % 256));
        end
        enable8 = 1'b0;
        step();
        check("t6_final", 32'(counter_out8), 32'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
